keyed_fsm_lock: RTL and testbench

Parametrised sequential key-lock stage for obfuscated benchmark FSMs. It sits between a functional controller core and the primary outputs, and holds the core disabled until a multi-word key sequence is applied on the correct cycles. Until then it scrambles the core outputs with an LFSR. It generalises single-bit duplicate-state locking to a configurable key width, sequence depth, failure mode and idle timeout, and adds relock.

---
 rtl/keyed_fsm_lock_pkg.sv | 26 ++
 rtl/keyed_fsm_lock_lfsr.sv | 42 ++++
 rtl/keyed_fsm_lock.sv | 154 +++++++++++++++
 tb/tb_keyed_fsm_lock.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keyed_fsm_lock_pkg.sv
// Shared types and constants for the keyed FSM lock: state encoding,
// failure-mode selectors and the scrambler tap table.
package keyed_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED    = 2'd0,
    UNLOCKED  = 2'd1,
    BLACKHOLE = 2'd2
  } lock_state_t;

  localparam int MODE_RETRY     = 0;
  localparam int MODE_BLACKHOLE = 1;

  // Feedback masks for a right-shifting Fibonacci LFSR: bit k of the mask
  // corresponds to polynomial term x^(W-k). Unsupported widths return 0.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_001D;  // x^8+x^6+x^5+x^4+1
      16:      return 32'h0000_002D;  // x^16+x^14+x^13+x^11+1
      24:      return 32'h0000_0087;  // x^24+x^23+x^22+x^17+1
      32:      return 32'hC000_0401;  // x^32+x^22+x^2+x^1+1
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/keyed_fsm_lock_lfsr.sv
// Fibonacci LFSR scrambler; shifts right with feedback into the MSB and
// holds its value whenever advance is low.
module lock_lfsr
  import keyed_lock_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(16'hACE1),
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(lfsr_taps(LFSR_W))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_reg, state_next;
  logic              feedback;

  if (TAPS == '0) begin : g_bad_taps
    $error("lock_lfsr: no tap mask for LFSR_W=%0d", LFSR_W);
  end

  assign feedback = ^(state_reg & TAPS);

  always_comb begin
    state_next = state_reg;
    if (advance) begin
      state_next = {feedback, state_reg[LFSR_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LFSR_SEED;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/keyed_fsm_lock.sv
// Sequential key lock: holds the guarded core disabled and scrambles its
// outputs until the configured key sequence is applied on consecutive key_valid edges.
module keyed_fsm_lock
  import keyed_lock_pkg::*;
#(
  parameter int                       KEY_W     = 8,
  parameter int                       SEQ_LEN   = 4,
  parameter logic [SEQ_LEN*KEY_W-1:0] KEY_SEQ   = 32'hE10F3CA5,
  parameter int                       OUT_W     = 16,
  parameter int                       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]        LFSR_SEED = 16'hACE1,
  parameter int                       MODE      = 0,
  parameter int                       TIMEOUT   = 0,
  localparam int                      SEQ_IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_W-1:0]     key_in,
  input  logic                 key_valid,
  input  logic                 relock,
  input  logic [OUT_W-1:0]     core_out,
  output logic                 core_en,
  output logic [OUT_W-1:0]     fn_out,
  output logic                 unlocked,
  output logic                 blackhole,
  output logic [SEQ_IDX_W-1:0] seq_idx
);

  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  lock_state_t          state_reg, state_next;
  logic [SEQ_IDX_W-1:0] seq_idx_reg, seq_idx_next;
  logic [IDLE_W-1:0]    idle_reg, idle_next;
  logic [OUT_W-1:0]     fn_out_reg, fn_out_next;
  logic [LFSR_W-1:0]    lfsr_state;
  logic                 lfsr_advance;
  logic [KEY_W-1:0]     step [SEQ_LEN];
  logic                 key_match, last_step, timeout_hit;

  if (OUT_W > LFSR_W) begin : g_bad_out_w
    $error("keyed_fsm_lock: OUT_W=%0d exceeds LFSR_W=%0d", OUT_W, LFSR_W);
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("keyed_fsm_lock: LFSR_SEED must be non-zero");
  end

  for (genvar gi = 0; gi < SEQ_LEN; gi++) begin : g_step
    assign step[gi] = KEY_SEQ[gi*KEY_W +: KEY_W];
  end

  assign key_match = (key_in == step[seq_idx_reg]);
  assign last_step = (seq_idx_reg == SEQ_IDX_W'(SEQ_LEN - 1));

  // Fires on the TIMEOUT-th consecutive idle cycle with a partial sequence.
  if (TIMEOUT > 0) begin : g_timeout
    assign timeout_hit = (idle_reg == IDLE_W'(TIMEOUT - 1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  lock_lfsr #(
    .LFSR_W   (LFSR_W),
    .LFSR_SEED(LFSR_SEED),
    .TAPS     (LFSR_W'(lfsr_taps(LFSR_W)))
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(lfsr_advance),
    .state  (lfsr_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= LOCKED;
      seq_idx_reg <= '0;
      idle_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      seq_idx_reg <= seq_idx_next;
      idle_reg    <= idle_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    seq_idx_next = seq_idx_reg;
    idle_next    = '0;
    case (state_reg)
      LOCKED: begin
        if (relock) begin
          seq_idx_next = '0;
        end else if (key_valid) begin
          if (key_match && last_step) begin
            state_next   = UNLOCKED;
            seq_idx_next = '0;
          end else if (key_match) begin
            seq_idx_next = seq_idx_reg + 1'b1;
          end else begin
            // No overlap matching: a wrong word always restarts at step 0.
            seq_idx_next = '0;
            if (MODE == MODE_BLACKHOLE) begin
              state_next = BLACKHOLE;
            end
          end
        end else if ((TIMEOUT > 0) && (seq_idx_reg != '0)) begin
          if (timeout_hit) begin
            seq_idx_next = '0;
          end else begin
            idle_next = idle_reg + 1'b1;
          end
        end
      end
      UNLOCKED: begin
        if (relock) begin
          state_next   = LOCKED;
          seq_idx_next = '0;
        end
      end
      BLACKHOLE: begin
        state_next = BLACKHOLE;
      end
      default: begin
        state_next   = LOCKED;
        seq_idx_next = '0;
      end
    endcase
  end

  // Outputs decode the registered state, so fn_out lags a state change by one edge.
  always_comb begin
    unlocked     = (state_reg == UNLOCKED);
    blackhole    = (state_reg == BLACKHOLE);
    core_en      = (state_reg == UNLOCKED);
    lfsr_advance = (state_reg != UNLOCKED);
    fn_out_next  = core_out ^ lfsr_state[OUT_W-1:0];
    case (state_reg)
      UNLOCKED:  fn_out_next = core_out;
      BLACKHOLE: fn_out_next = lfsr_state[OUT_W-1:0];
      default:   fn_out_next = core_out ^ lfsr_state[OUT_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fn_out_reg <= '0;
    end else begin
      fn_out_reg <= fn_out_next;
    end
  end

  assign fn_out  = fn_out_reg;
  assign seq_idx = seq_idx_reg;

endmodule

// File: tb/tb_keyed_fsm_lock.sv
// Directed bench for keyed_fsm_lock: three instances (retry, black hole,
// timeout=3) share one stimulus stream; each scenario checks its own instance.
module tb_keyed_fsm_lock;

  logic        clk;
  logic        rst_n;
  logic [7:0]  key_in;
  logic        key_valid;
  logic        relock;
  logic [15:0] core_out;

  logic        u0_core_en, u0_unlocked, u0_blackhole;
  logic [15:0] u0_fn_out;
  logic [1:0]  u0_seq_idx;
  logic        u1_core_en, u1_unlocked, u1_blackhole;
  logic [15:0] u1_fn_out;
  logic [1:0]  u1_seq_idx;
  logic        u2_core_en, u2_unlocked, u2_blackhole;
  logic [15:0] u2_fn_out;
  logic [1:0]  u2_seq_idx;

  int checks = 0;
  int errors = 0;

  logic [7:0]  steps [4] = '{8'hA5, 8'h3C, 8'h0F, 8'hE1};
  logic [15:0] m;

  keyed_fsm_lock u0 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .relock(relock), .core_out(core_out), .core_en(u0_core_en),
    .fn_out(u0_fn_out), .unlocked(u0_unlocked), .blackhole(u0_blackhole),
    .seq_idx(u0_seq_idx)
  );

  keyed_fsm_lock #(.MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .relock(relock), .core_out(core_out), .core_en(u1_core_en),
    .fn_out(u1_fn_out), .unlocked(u1_unlocked), .blackhole(u1_blackhole),
    .seq_idx(u1_seq_idx)
  );

  keyed_fsm_lock #(.TIMEOUT(3)) u2 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .relock(relock), .core_out(core_out), .core_en(u2_core_en),
    .fn_out(u2_fn_out), .unlocked(u2_unlocked), .blackhole(u2_blackhole),
    .seq_idx(u2_seq_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // x^16+x^14+x^13+x^11+1, shifting right, feedback into bit 15.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t key=%h v=%b rl=%b rst_n=%b core=%h | seq=%0d/%0d/%0d unl=%b/%b/%b bh=%b fn=%h/%h/%h",
             $time, key_in, key_valid, relock, rst_n, core_out,
             u0_seq_idx, u1_seq_idx, u2_seq_idx, u0_unlocked, u1_unlocked, u2_unlocked,
             u1_blackhole, u0_fn_out, u1_fn_out, u2_fn_out);
  endtask

  task automatic send_key(input logic [7:0] k);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    relock    = 1'b0;
    key_in    = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    core_out = 16'hFFFF;
    do_reset();
    checks++; if (u0_seq_idx !== 2'd0) begin errors++; $display("FAIL reset_seq_idx: got %0d expected 0", u0_seq_idx); end
    checks++; if (u0_unlocked !== 1'b0) begin errors++; $display("FAIL reset_unlocked: got %b expected 0", u0_unlocked); end
    checks++; if (u0_core_en !== 1'b0) begin errors++; $display("FAIL reset_core_en: got %b expected 0", u0_core_en); end
    checks++; if (u0_fn_out !== 16'h0000) begin errors++; $display("FAIL reset_fn_out: got %h expected 0000", u0_fn_out); end
    checks++; if (u1_blackhole !== 1'b0) begin errors++; $display("FAIL reset_blackhole: got %b expected 0", u1_blackhole); end
  endtask

  task automatic test_scramble();
    do_reset();
    core_out = 16'h0000;
    m = 16'hACE1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (u0_fn_out !== m) begin errors++; $display("FAIL scramble_lfsr%0d: got %h expected %h", i, u0_fn_out, m); end
      m = lfsr_adv(m);
    end
    core_out = 16'h00FF;
    tick();
    checks++; if (u0_fn_out !== (16'h00FF ^ m)) begin errors++; $display("FAIL scramble_xor: got %h expected %h", u0_fn_out, 16'h00FF ^ m); end
  endtask

  task automatic test_unlock();
    do_reset();
    core_out = 16'h1234;
    m = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      send_key(steps[i]);
      checks++; if (u0_seq_idx !== 2'((i + 1) % 4)) begin errors++; $display("FAIL unlock_seq_step%0d: got %0d expected %0d", i, u0_seq_idx, (i + 1) % 4); end
      if (i < 3) m = lfsr_adv(m);
    end
    checks++; if (u0_unlocked !== 1'b1) begin errors++; $display("FAIL unlock_unlocked: got %b expected 1", u0_unlocked); end
    checks++; if (u0_core_en !== 1'b1) begin errors++; $display("FAIL unlock_core_en: got %b expected 1", u0_core_en); end
    checks++; if (u0_fn_out !== (16'h1234 ^ m)) begin errors++; $display("FAIL unlock_fn_still_scrambled: got %h expected %h", u0_fn_out, 16'h1234 ^ m); end
    tick();
    checks++; if (u0_fn_out !== 16'h1234) begin errors++; $display("FAIL unlock_fn_clear: got %h expected 1234", u0_fn_out); end
    core_out = 16'hBEEF;
    tick();
    checks++; if (u0_fn_out !== 16'hBEEF) begin errors++; $display("FAIL unlock_core_latency: got %h expected beef", u0_fn_out); end
  endtask

  task automatic test_retry();
    do_reset();
    send_key(8'hA5);
    send_key(8'h3C);
    checks++; if (u0_seq_idx !== 2'd2) begin errors++; $display("FAIL retry_seq2: got %0d expected 2", u0_seq_idx); end
    send_key(8'hFF);
    checks++; if (u0_seq_idx !== 2'd0) begin errors++; $display("FAIL retry_mismatch_seq: got %0d expected 0", u0_seq_idx); end
    checks++; if (u0_unlocked !== 1'b0) begin errors++; $display("FAIL retry_unlocked: got %b expected 0", u0_unlocked); end
    send_key(8'hA5);
    send_key(8'h3C);
    send_key(8'hA5);
    checks++; if (u0_seq_idx !== 2'd0) begin errors++; $display("FAIL retry_no_overlap: got %0d expected 0", u0_seq_idx); end
    for (int i = 0; i < 4; i++) send_key(steps[i]);
    checks++; if (u0_unlocked !== 1'b1) begin errors++; $display("FAIL retry_then_unlock: got %b expected 1", u0_unlocked); end
  endtask

  task automatic test_blackhole();
    do_reset();
    core_out = 16'h5555;
    m = 16'hACE1;
    send_key(8'hA5);
    m = lfsr_adv(m);
    checks++; if (u1_seq_idx !== 2'd1) begin errors++; $display("FAIL bh_seq1: got %0d expected 1", u1_seq_idx); end
    send_key(8'h00);
    checks++; if (u1_blackhole !== 1'b1) begin errors++; $display("FAIL bh_trap: got %b expected 1", u1_blackhole); end
    checks++; if (u1_fn_out !== (16'h5555 ^ m)) begin errors++; $display("FAIL bh_trap_edge_fn: got %h expected %h", u1_fn_out, 16'h5555 ^ m); end
    m = lfsr_adv(m);
    for (int i = 0; i < 4; i++) begin
      core_out = 16'h1111 * 16'(i + 1);
      relock   = (i == 3);
      send_key(steps[i]);
      relock = 1'b0;
      checks++; if (u1_blackhole !== 1'b1 || u1_unlocked !== 1'b0) begin errors++; $display("FAIL bh_absorb%0d: got bh=%b unl=%b expected bh=1 unl=0", i, u1_blackhole, u1_unlocked); end
      checks++; if (u1_fn_out !== m) begin errors++; $display("FAIL bh_fn_lfsr%0d: got %h expected %h", i, u1_fn_out, m); end
      m = lfsr_adv(m);
    end
    do_reset();
    checks++; if (u1_blackhole !== 1'b0) begin errors++; $display("FAIL bh_reset_exit: got %b expected 0", u1_blackhole); end
    checks++; if (u1_fn_out !== 16'h0000) begin errors++; $display("FAIL bh_reset_fn: got %h expected 0000", u1_fn_out); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_key(8'hA5);
    send_key(8'h3C);
    tick();
    tick();
    checks++; if (u2_seq_idx !== 2'd2) begin errors++; $display("FAIL timeout_two_idle: got %0d expected 2", u2_seq_idx); end
    tick();
    checks++; if (u2_seq_idx !== 2'd0) begin errors++; $display("FAIL timeout_expired: got %0d expected 0", u2_seq_idx); end
    checks++; if (u0_seq_idx !== 2'd2) begin errors++; $display("FAIL timeout_disabled_hold: got %0d expected 2", u0_seq_idx); end
    send_key(8'h0F);
    checks++; if (u2_seq_idx !== 2'd0) begin errors++; $display("FAIL timeout_then_0f: got %0d expected 0", u2_seq_idx); end
    checks++; if (u0_seq_idx !== 2'd3) begin errors++; $display("FAIL timeout_disabled_0f: got %0d expected 3", u0_seq_idx); end
    do_reset();
    send_key(8'hA5);
    tick();
    tick();
    send_key(8'h3C);
    tick();
    tick();
    checks++; if (u2_seq_idx !== 2'd2) begin errors++; $display("FAIL timeout_restart_on_key: got %0d expected 2", u2_seq_idx); end
    send_key(8'h0F);
    checks++; if (u2_seq_idx !== 2'd3) begin errors++; $display("FAIL timeout_key_wins: got %0d expected 3", u2_seq_idx); end
  endtask

  task automatic test_relock();
    do_reset();
    core_out = 16'h0000;
    m = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      send_key(steps[i]);
      m = lfsr_adv(m);
    end
    tick();
    tick();
    tick();
    checks++; if (u0_unlocked !== 1'b1) begin errors++; $display("FAIL relock_pre_unlocked: got %b expected 1", u0_unlocked); end
    relock = 1'b1;
    send_key(8'hA5);
    relock = 1'b0;
    checks++; if (u0_unlocked !== 1'b0 || u0_core_en !== 1'b0) begin errors++; $display("FAIL relock_race_state: got unl=%b en=%b expected 0/0", u0_unlocked, u0_core_en); end
    checks++; if (u0_seq_idx !== 2'd0) begin errors++; $display("FAIL relock_race_seq: got %0d expected 0", u0_seq_idx); end
    tick();
    checks++; if (u0_fn_out !== m) begin errors++; $display("FAIL relock_lfsr_frozen: got %h expected %h", u0_fn_out, m); end
    send_key(8'hA5);
    send_key(8'h3C);
    relock = 1'b1;
    send_key(8'h0F);
    relock = 1'b0;
    checks++; if (u0_seq_idx !== 2'd0) begin errors++; $display("FAIL relock_locked_clear: got %0d expected 0", u0_seq_idx); end
    send_key(8'hA5);
    checks++; if (u0_seq_idx !== 2'd1) begin errors++; $display("FAIL relock_restart: got %0d expected 1", u0_seq_idx); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_key(8'hA5);
    send_key(8'h3C);
    rst_n = 1'b0;
    #1;
    checks++; if (u0_seq_idx !== 2'd0) begin errors++; $display("FAIL rstmid_async_seq: got %0d expected 0", u0_seq_idx); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_key(8'h0F);
    send_key(8'hE1);
    checks++; if (u0_unlocked !== 1'b0 || u0_seq_idx !== 2'd0) begin errors++; $display("FAIL rstmid_no_resume: got unl=%b seq=%0d expected 0/0", u0_unlocked, u0_seq_idx); end
    for (int i = 0; i < 4; i++) send_key(steps[i]);
    rst_n = 1'b0;
    #1;
    checks++; if (u0_unlocked !== 1'b0 || u0_core_en !== 1'b0) begin errors++; $display("FAIL rst_while_unlocked: got unl=%b en=%b expected 0/0", u0_unlocked, u0_core_en); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    key_in    = 8'h00;
    key_valid = 1'b0;
    relock    = 1'b0;
    core_out  = 16'h0000;
    test_reset();
    test_scramble();
    test_unlock();
    test_retry();
    test_blackhole();
    test_timeout();
    test_relock();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
